control: RTL and testbench
==========================

# control

Main decoder plus ALU decoder for the single-cycle RV32I datapath. It turns the current instruction's opcode, funct3 and funct7[5] fields, together with the ALU Zero flag, into all datapath select and write-enable signals within the same cycle. A small clocked block alongside the decoder records illegal-instruction events for debug.

## Interface
- No parameters.
- clk  input  1  rising-edge clock; used only by the illegal-event status registers.
- rst_n  input  1  reset, asynchronous, active-low.
- op  input  7  instruction[6:0].
- funct3  input  3  instruction[14:12].
- funct7  input  1  instruction[30] (funct7 bit 5).
- Zero  input  1  ALU result-is-zero flag.
- PCSrc  output  1  1 = take the branch target (PC+imm); 0 = PC+4.
- ResultSrc  output  1  1 = write back memory read data; 0 = write back the ALU result.
- MemWrite  output  1  data-memory write enable.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrc  output  1  1 = ALU operand B is the immediate; 0 = operand B is rs2.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B.
- RegWrite  output  1  register-file write enable.
- Illegal  output  1  combinational flag: the current instruction is unsupported.
- IllegalSticky  output  1  registered; set by any illegal cycle, cleared only by reset.
- IllegalCount  output  8  registered count of illegal cycles; saturates at 255.

## Operation
Main decoder, keyed on op. Fields listed in order RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp:
- 0000011 (lw): 1, 00, 1, 0, 1, 0, 00.
- 0100011 (sw): 0, 01, 1, 1, 0, 0, 00.
- 0110011 (R-type): 1, 00, 0, 0, 0, 0, 10.
- 0010011 (I-type ALU): 1, 00, 1, 0, 0, 0, 10.
- 1100011 (beq): 0, 10, 0, 0, 0, 1, 01.
- Any other op: every field 0, and Illegal=1.

PCSrc = Branch AND Zero.

ALU decoder:
- ALUOp 00 selects add; ALUOp 01 selects sub. funct3 is ignored for lw, sw and beq.
- ALUOp 10, funct3=000: sub when op[5]=1 and funct7=1; add otherwise. This makes addi with funct7=1 an add.
- ALUOp 10, funct3=010: slt.
- ALUOp 10, funct3=110: or.
- ALUOp 10, funct3=111: and.
- ALUOp 10, funct3 in {001, 011, 100, 101}: ALUControl=000 and Illegal=1.
- funct7 matters only for funct3=000.

Status registers:
- On every rising clk edge where Illegal=1: IllegalSticky becomes 1 and IllegalCount increments by 1, holding at 8'hFF.
- rst_n=0 clears both registers to 0 immediately, independent of clk, and holds them at 0 while asserted.

## Timing
- All decode outputs are purely combinational from op, funct3, funct7 and Zero. Latency is zero, there is no handshake, and outputs settle within the same cycle.
- Reset does not affect decode outputs; they follow the inputs even while rst_n=0.
- IllegalSticky and IllegalCount change only on a clk edge or asynchronously on reset. An illegal instruction becomes visible on them one cycle after it appears on the inputs.
- Reset values: IllegalSticky=0, IllegalCount=0.
- Reset released in the same cycle that Illegal=1: no count is taken at that edge if rst_n is still low at the edge.
- Saturation: a further illegal cycle with IllegalCount=255 leaves the count at 255.

## Configuration
- CONTROL_ILLEGAL_SQUASH_EN defined: when Illegal=1, RegWrite, MemWrite and PCSrc are forced to 0. All other outputs keep their decoded values.
- CONTROL_ILLEGAL_SQUASH_EN undefined: no forcing is applied.
  - An unsupported R-type or I-type funct3 gives RegWrite=1 with ALUControl=000.
  - An unknown op already gives all-zero controls.
- The Illegal output, IllegalSticky and IllegalCount exist in both builds.

## Test plan
- op=03, funct3=0 -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=1, ALUControl=000, PCSrc=0. Then op=23 -> MemWrite=1, RegWrite=0, ImmSrc=01, ALUSrc=1.
- op=63, Zero=0 -> PCSrc=0, ImmSrc=10, ALUControl=001. Set Zero=1 -> PCSrc=1.
- op=33, funct3=0: funct7=1 -> ALUControl=001. funct7=0 -> 000. op=13 with funct7=1 -> 000.
- op=33, funct7=0, funct3 = 2/6/7 -> ALUControl = 101/011/010, Illegal=0. funct3=1 -> Illegal=1, ALUControl=000, and RegWrite=0 only when CONTROL_ILLEGAL_SQUASH_EN is defined.
- op=00 held for 300 clk cycles -> all decode outputs 0, Illegal=1, IllegalSticky=1 after the first edge, IllegalCount saturates at 255.
- Pulse rst_n low between clock edges -> IllegalSticky=0 and IllegalCount=0 immediately. Decode outputs are unchanged during the pulse.

Source files
------------

// File: rtl/control.sv
// Single-cycle RV32I main + ALU decoder with illegal-instruction status.
// Define CONTROL_ILLEGAL_SQUASH_EN to gate RegWrite/MemWrite/PCSrc on Illegal.
module control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCSrc,
    output logic       ResultSrc,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic       IllegalSticky,
    output logic [7:0] IllegalCount
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_i;
    logic is_beq;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_beq = (op == OP_BEQ);

    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       illegal_f3;

    always_comb begin
        reg_write  = 1'b0;
        ImmSrc     = 2'b00;
        ALUSrc     = 1'b0;
        mem_write  = 1'b0;
        ResultSrc  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        unique case (1'b1)
            is_lw: begin
                reg_write = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = 1'b1;
            end
            is_sw: begin
                ImmSrc    = 2'b01;
                ALUSrc    = 1'b1;
                mem_write = 1'b1;
            end
            is_r: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            is_i: begin
                reg_write = 1'b1;
                ALUSrc    = 1'b1;
                alu_op    = 2'b10;
            end
            is_beq: begin
                ImmSrc = 2'b10;
                branch = 1'b1;
                alu_op = 2'b01;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // Only register-register funct3=000 with funct7 set is a subtract.
    always_comb begin
        ALUControl = ALU_ADD;
        illegal_f3 = 1'b0;
        unique case (alu_op)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: illegal_f3 = 1'b1;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    assign Illegal = illegal_op | illegal_f3;

`ifdef CONTROL_ILLEGAL_SQUASH_EN
    assign RegWrite = reg_write & ~Illegal;
    assign MemWrite = mem_write & ~Illegal;
    assign PCSrc    = branch & Zero & ~Illegal;
`else
    assign RegWrite = reg_write;
    assign MemWrite = mem_write;
    assign PCSrc    = branch & Zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IllegalSticky <= 1'b0;
            IllegalCount  <= 8'd0;
        end else if (Illegal) begin
            IllegalSticky <= 1'b1;
            if (IllegalCount != 8'hFF)
                IllegalCount <= IllegalCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_control.sv
// Randomized + directed bench for control against a behavioural decode model.
module tb_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       PCSrc;
    logic       ResultSrc;
    logic       MemWrite;
    logic [2:0] ALUControl;
    logic       ALUSrc;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       Illegal;
    logic       IllegalSticky;
    logic [7:0] IllegalCount;

    control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7(funct7), .Zero(Zero), .PCSrc(PCSrc),
        .ResultSrc(ResultSrc), .MemWrite(MemWrite),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .Illegal(Illegal),
        .IllegalSticky(IllegalSticky), .IllegalCount(IllegalCount)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cnt_m = 0;
    bit sticky_m = 1'b0;

    typedef struct packed {
        logic       pcsrc;
        logic       resultsrc;
        logic       memwrite;
        logic [2:0] alu;
        logic       alusrc;
        logic [1:0] imm;
        logic       regwrite;
        logic       illegal;
    } exp_t;

    exp_t e;

    function automatic exp_t model(logic [6:0] o, logic [2:0] f3,
                                   logic f7, logic z);
        exp_t r;
        bit   br;
        bit   arith;
        r = '0;
        br = 1'b0;
        arith = 1'b0;
        case (o)
            7'h03: begin r.regwrite = 1; r.alusrc = 1; r.resultsrc = 1; end
            7'h23: begin r.imm = 2'd1; r.alusrc = 1; r.memwrite = 1; end
            7'h33: begin r.regwrite = 1; arith = 1; end
            7'h13: begin r.regwrite = 1; r.alusrc = 1; arith = 1; end
            7'h63: begin r.imm = 2'd2; br = 1; r.alu = 3'd1; end
            default: r.illegal = 1;
        endcase
        if (arith) begin
            case (f3)
                3'd0: r.alu = (o == 7'h33 && f7) ? 3'd1 : 3'd0;
                3'd2: r.alu = 3'd5;
                3'd6: r.alu = 3'd3;
                3'd7: r.alu = 3'd2;
                default: r.illegal = 1;
            endcase
        end
        r.pcsrc = br & z;
`ifdef CONTROL_ILLEGAL_SQUASH_EN
        if (r.illegal) begin
            r.regwrite = 0;
            r.memwrite = 0;
            r.pcsrc = 0;
        end
`endif
        return r;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h (op=%0h f3=%0d f7=%0b z=%0b)",
                   tag, obs, expv, op, funct3, funct7, Zero);
        end
    endtask

    task automatic check_decode();
        e = model(op, funct3, funct7, Zero);
        chk("PCSrc", {7'd0, PCSrc}, {7'd0, e.pcsrc});
        chk("ResultSrc", {7'd0, ResultSrc}, {7'd0, e.resultsrc});
        chk("MemWrite", {7'd0, MemWrite}, {7'd0, e.memwrite});
        chk("ALUControl", {5'd0, ALUControl}, {5'd0, e.alu});
        chk("ALUSrc", {7'd0, ALUSrc}, {7'd0, e.alusrc});
        chk("ImmSrc", {6'd0, ImmSrc}, {6'd0, e.imm});
        chk("RegWrite", {7'd0, RegWrite}, {7'd0, e.regwrite});
        chk("Illegal", {7'd0, Illegal}, {7'd0, e.illegal});
    endtask

    task automatic check_regs();
        chk("IllegalSticky", {7'd0, IllegalSticky}, {7'd0, sticky_m});
        chk("IllegalCount", IllegalCount, cnt_m[7:0]);
    endtask

    task automatic step(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        op = o;
        funct3 = f3;
        funct7 = f7;
        Zero = z;
        #1;
        check_decode();
        @(posedge clk);
        if (rst_n && e.illegal) begin
            sticky_m = 1'b1;
            if (cnt_m < 255) cnt_m++;
        end
        #1;
        check_regs();
    endtask

    logic [6:0] ops [5];

    initial begin
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
        ops[3] = 7'h13; ops[4] = 7'h63;
        rst_n = 1'b0;
        op = 7'h03; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;
        @(posedge clk);
        #1;
        check_regs();

        // illegal input while reset is held across an edge: not counted
        step(7'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(7'h03, 3'd0, 1'b0, 1'b0);

        step(7'h23, 3'd5, 1'b1, 1'b0);
        step(7'h63, 3'd0, 1'b0, 1'b0);
        step(7'h63, 3'd0, 1'b0, 1'b1);
        step(7'h33, 3'd0, 1'b1, 1'b0);
        step(7'h33, 3'd0, 1'b0, 1'b0);
        step(7'h13, 3'd0, 1'b1, 1'b0);
        step(7'h33, 3'd2, 1'b0, 1'b0);
        step(7'h33, 3'd6, 1'b0, 1'b0);
        step(7'h33, 3'd7, 1'b0, 1'b0);
        step(7'h33, 3'd1, 1'b0, 1'b1);
        step(7'h13, 3'd5, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] o;
            int k;
            k = $urandom_range(0, 5);
            o = (k == 5) ? 7'($urandom) : ops[k];
            step(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 300; i++)
            step(7'h00, 3'($urandom), 1'($urandom), 1'($urandom));

        // asynchronous reset pulse between edges
        op = 7'h00; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        sticky_m = 1'b0;
        cnt_m = 0;
        check_regs();
        check_decode();
        rst_n = 1'b1;
        #1;
        check_decode();

        step(7'h00, 3'd0, 1'b0, 1'b0);
        step(7'h63, 3'd3, 1'b1, 1'b1);
        step(7'h7f, 3'd7, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
